// File: rtl/button_step_pkg.sv
// ============================================================================
// Module   : button_step_pkg
// Summary  : Shared LED display-mode codes and state-width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package button_step_pkg;

    localparam int MODE_ONEHOT = 0;
    localparam int MODE_BAR    = 1;
    localparam int MODE_BINARY = 2;

    // A single-state counter would give $clog2 = 0; keep at least one bit.
    function automatic int state_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module   : button_debounce
// Summary  : 2-flop synchroniser plus counter debouncer for an active-low
//            button; emits a one-cycle press event on an accepted press.
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q,   deb_d;
    logic [DEB_W-1:0] cnt_q,   cnt_d;
    logic             differ;
    logic             cnt_full;

    always_comb begin
        sync1_d  = ~btn_n;
        sync2_d  = sync1_q;
        differ   = sync2_q ^ deb_q;
        cnt_full = &cnt_q;
        deb_d    = deb_q;
        cnt_d    = '0;
        if (differ) begin
            if (cnt_full) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only the rising edge of the debounced level is an event.
    assign press = differ & cnt_full & ~deb_q;
    assign level = deb_q;

endmodule

`default_nettype wire

// File: rtl/button_step_fsm.sv
// ============================================================================
// Module   : button_step_fsm
// Summary  : Two-button up/down N-state stepper with wrap/saturate ends and a
//            one-hot, bar or binary LED decode of the current state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_step_fsm
    import button_step_pkg::*;
#(
    parameter int  N_STATES = 4,
    parameter int  LED_W    = 4,
    parameter int  DEB_W    = 16,
    parameter int  WRAP     = 1,
    parameter int  MODE     = 0,
    localparam int SW       = state_width(N_STATES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    output logic [LED_W-1:0] led,
    output logic [SW-1:0]    state,
    output logic             step
);

    localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);

    logic          up_ev, dn_ev;
    logic          lvl_up, lvl_dn;
    logic          unused_levels;
    logic [SW-1:0] state_q, state_d;
    logic          step_q,  step_d;

    button_debounce #(.DEB_W(DEB_W)) u_deb_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_up_n),
        .level (lvl_up),
        .press (up_ev)
    );

    button_debounce #(.DEB_W(DEB_W)) u_deb_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_dn_n),
        .level (lvl_dn),
        .press (dn_ev)
    );

    assign unused_levels = lvl_up ^ lvl_dn;

    always_comb begin
        state_d = state_q;
        if (state_q > LAST) begin
            state_d = '0;
        end else if (up_ev && !dn_ev) begin
            if (state_q == LAST) begin
                state_d = (WRAP != 0) ? '0 : state_q;
            end else begin
                state_d = state_q + 1'b1;
            end
        end else if (dn_ev && !up_ev) begin
            if (state_q == '0) begin
                state_d = (WRAP != 0) ? LAST : state_q;
            end else begin
                state_d = state_q - 1'b1;
            end
        end
        // Saturated holds and cancelled simultaneous presses leave step low.
        step_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    generate
        if (MODE == MODE_BINARY) begin : g_binary
            always_comb begin
                led = LED_W'(state_q);
            end
        end else if (MODE == MODE_BAR) begin : g_bar
            always_comb begin
                led = '0;
                for (int k = 0; k < LED_W; k++) begin
                    led[k] = (int'(state_q) >= k);
                end
            end
        end else begin : g_onehot
            always_comb begin
                led = '0;
                for (int k = 0; k < LED_W; k++) begin
                    led[k] = (int'(state_q) == k);
                end
            end
        end
    endgenerate

    assign state = state_q;
    assign step  = step_q;

endmodule

`default_nettype wire

// File: tb/tb_button_step_fsm.sv
// ============================================================================
// Module   : tb_button_step_fsm
// Summary  : Four configurations of button_step_fsm driven by shared buttons,
//            checked against hand-computed vectors and timing sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_button_step_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up_n;
    logic       btn_dn_n;

    logic [3:0] led_a, led_c, led_d;
    logic [4:0] led_b;
    logic [1:0] state_a, state_c;
    logic [2:0] state_b, state_d;
    logic       step_a, step_b, step_c, step_d;

    int n_checks = 0;
    int n_fail   = 0;
    int steps_a = 0, steps_b = 0, steps_c = 0, steps_d = 0;

    always #5 clk = ~clk;

    // A: N=4 wrap one-hot, B: N=5 saturate one-hot, C: N=4 bar, D: N=8 binary
    button_step_fsm #(.N_STATES(4), .LED_W(4), .DEB_W(4), .WRAP(1), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .led(led_a), .state(state_a), .step(step_a));
    button_step_fsm #(.N_STATES(5), .LED_W(5), .DEB_W(4), .WRAP(0), .MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .led(led_b), .state(state_b), .step(step_b));
    button_step_fsm #(.N_STATES(4), .LED_W(4), .DEB_W(4), .WRAP(1), .MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .led(led_c), .state(state_c), .step(step_c));
    button_step_fsm #(.N_STATES(8), .LED_W(4), .DEB_W(4), .WRAP(1), .MODE(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .led(led_d), .state(state_d), .step(step_d));

    always @(negedge clk) begin
        if (step_a) steps_a++;
        if (step_b) steps_b++;
        if (step_c) steps_c++;
        if (step_d) steps_d++;
    end

    typedef struct {
        bit       up;
        bit       dn;
        int       sa, sb, sc, sd;
        int       la, lb, lc, ld;
        bit [3:0] stp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit up, input bit dn);
        @(negedge clk);
        btn_up_n = ~up;
        btn_dn_n = ~dn;
        repeat (40) @(negedge clk);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int pa, pb, pc, pd;

        vecs[0] = '{1, 0, 2, 2, 2, 2, 4'b0100, 5'b00100, 4'b0111, 4'b0010, 4'b1111};
        vecs[1] = '{1, 0, 3, 3, 3, 3, 4'b1000, 5'b01000, 4'b1111, 4'b0011, 4'b1111};
        vecs[2] = '{1, 0, 0, 4, 0, 4, 4'b0001, 5'b10000, 4'b0001, 4'b0100, 4'b1111};
        vecs[3] = '{1, 0, 1, 4, 1, 5, 4'b0010, 5'b10000, 4'b0011, 4'b0101, 4'b1011};
        vecs[4] = '{1, 0, 2, 4, 2, 6, 4'b0100, 5'b10000, 4'b0111, 4'b0110, 4'b1011};
        vecs[5] = '{0, 1, 1, 3, 1, 5, 4'b0010, 5'b01000, 4'b0011, 4'b0101, 4'b1111};
        vecs[6] = '{1, 1, 1, 3, 1, 5, 4'b0010, 5'b01000, 4'b0011, 4'b0101, 4'b0000};
        vecs[7] = '{0, 1, 0, 2, 0, 4, 4'b0001, 5'b00100, 4'b0001, 4'b0100, 4'b1111};
        vecs[8] = '{0, 1, 3, 1, 3, 3, 4'b1000, 5'b00010, 4'b1111, 4'b0011, 4'b1111};

        rst_n    = 1'b0;
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset state_a", int'(state_a), 0);
        check("reset led_a", int'(led_a), 4'b0001);
        check("reset step_a", int'(step_a), 0);
        check("reset led_b", int'(led_b), 5'b00001);
        check("reset led_c", int'(led_c), 4'b0001);
        check("reset led_d", int'(led_d), 0);

        // First press: state must change exactly at E0 + 2^DEB_W + 1.
        @(negedge clk);
        btn_up_n = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("timing state_a before", int'(state_a), 0);
        check("timing step_a before", int'(step_a), 0);
        @(posedge clk);
        #1;
        check("timing state_a at edge", int'(state_a), 1);
        check("timing led_a at edge", int'(led_a), 4'b0010);
        check("timing step_a at edge", int'(step_a), 1);
        @(posedge clk);
        #1;
        check("timing step_a after", int'(step_a), 0);
        repeat (40) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (40) @(negedge clk);
        check("held press single step", steps_a, 1);

        // Bounce: 5 low / 3 high never reaches the 16-cycle stable window.
        pa = steps_a;
        pd = steps_d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            btn_up_n = ((i % 8) < 5) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        btn_up_n = 1'b1;
        repeat (40) @(negedge clk);
        check("bounce state_a", int'(state_a), 1);
        check("bounce steps_a", steps_a - pa, 0);
        check("bounce state_d", int'(state_d), 1);
        check("bounce steps_d", steps_d - pd, 0);

        for (int v = 0; v < 9; v++) begin
            pa = steps_a; pb = steps_b; pc = steps_c; pd = steps_d;
            press(vecs[v].up, vecs[v].dn);
            check($sformatf("v%0d state_a", v), int'(state_a), vecs[v].sa);
            check($sformatf("v%0d state_b", v), int'(state_b), vecs[v].sb);
            check($sformatf("v%0d state_c", v), int'(state_c), vecs[v].sc);
            check($sformatf("v%0d state_d", v), int'(state_d), vecs[v].sd);
            check($sformatf("v%0d led_a", v), int'(led_a), vecs[v].la);
            check($sformatf("v%0d led_b", v), int'(led_b), vecs[v].lb);
            check($sformatf("v%0d led_c", v), int'(led_c), vecs[v].lc);
            check($sformatf("v%0d led_d", v), int'(led_d), vecs[v].ld);
            check($sformatf("v%0d steps_a", v), steps_a - pa, int'(vecs[v].stp[3]));
            check($sformatf("v%0d steps_b", v), steps_b - pb, int'(vecs[v].stp[2]));
            check($sformatf("v%0d steps_c", v), steps_c - pc, int'(vecs[v].stp[1]));
            check($sformatf("v%0d steps_d", v), steps_d - pd, int'(vecs[v].stp[0]));
        end

        // Reset mid-debounce with the button kept held.
        @(negedge clk);
        btn_up_n = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midreset counter", int'(dut_a.u_deb_up.cnt_q), 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset state_a", int'(state_a), 0);
        check("midreset state_b", int'(state_b), 0);
        check("midreset step_a", int'(step_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        check("postreset state_a before", int'(state_a), 0);
        @(posedge clk);
        #1;
        check("postreset state_a at edge", int'(state_a), 1);
        check("postreset step_a at edge", int'(step_a), 1);
        check("postreset state_d at edge", int'(state_d), 1);
        repeat (40) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_step_fsm.md
# button_step_fsm

Parametrised successor to the single-button LED cycler. It debounces two raw active-low push-buttons (up and down) and steps an N-state counter FSM forwards or backwards, with wrap or saturate at the ends. The FSM state is decoded onto an LED bus in one of three display modes. It sits between board-level button pins and LED pins, clocked by the board clock.

## Interface
Parameters:
- N_STATES, default 4: number of FSM states, legal range 2..16; SW = $clog2(N_STATES).
- LED_W, default 4: LED bus width. Must be >= N_STATES for one-hot and bar modes, and >= SW for binary mode.
- DEB_W, default 16: debounce counter width; a level must be stable for 2^DEB_W cycles to be accepted.
- WRAP, default 1: 1 = wrap at the ends; 0 = saturate at 0 and at N_STATES-1.
- MODE, default 0: LED decode. 0 = one-hot, 1 = bar (thermometer), 2 = binary.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up_n  in  1  raw up button, active-low, asynchronous to clk.
- btn_dn_n  in  1  raw down button, active-low, asynchronous to clk.
- led  out  LED_W  decoded state.
- state  out  SW  current FSM state.
- step  out  1  one-cycle pulse, high in the first cycle a new state value is present.

## Operation
- Each button passes through a 2-flop synchroniser that stores the inverted input, so 1 = pressed.
- Each button has a debouncer with a registered debounced level (deb) and a DEB_W-bit counter.
  - When the synced level equals deb, the counter is held at 0.
  - Otherwise the counter increments each cycle. When it is all-ones and the levels still differ, deb toggles and the counter returns to 0.
  - A press event is combinational: levels differ, counter all-ones, and deb = 0.
  - Releases produce no event.
- FSM update rules, applied on the edge after a press event:
  - Up event alone: state+1. At N_STATES-1, go to 0 if WRAP=1, otherwise hold.
  - Down event alone: state-1. At 0, go to N_STATES-1 if WRAP=1, otherwise hold.
  - Up and down events in the same cycle: no change, and step stays low.
  - A saturated hold is not a change, so step stays low.
- step is registered and is high exactly when the state register changed on the preceding edge.
- LED decode is combinational from the state register; unused upper bits are 0.
  - One-hot: led[state] = 1.
  - Bar: led[k] = 1 for all k <= state.
  - Binary: led[SW-1:0] = state.
- State values >= N_STATES are unreachable. If one is ever present, the next edge forces state to 0.
- Reset values: sync flops 0, deb 0, counters 0, state 0, step 0.
  - led after reset: 0...01 in one-hot and bar modes, all zeros in binary mode.
- Asserting rst_n low mid-debounce discards the pending press. A button still held after reset is accepted as a new press after the full debounce time.

## Timing
- Let E0 be the first rising edge that samples btn_*_n low; the button then stays low.
  - The synced level rises after E0+1.
  - The counter holds value k after edge E0+1+k.
  - The press event is high during the cycle following edge E0+2^DEB_W.
  - state, led and step update at edge E0+2^DEB_W+1.
- A glitch or bounce shorter than 2^DEB_W stable cycles restarts the counter and yields no event.
- A held button yields exactly one event. Auto-repeat is not provided.
- Minimum spacing between accepted presses on one button: 2 × 2^DEB_W cycles (release debounce plus press debounce).

## Structure
- Package button_step_pkg holds:
  - MODE_ONEHOT = 0, MODE_BAR = 1, MODE_BINARY = 2;
  - a state-width function wrapping $clog2.
- Sub-module button_debounce (parameter DEB_W; ports clk, rst_n, btn_n, level, press) is instantiated twice.
- The top level holds the FSM, the step register and the LED decode.

## Test plan
All scenarios use DEB_W=4 unless stated.
- Reset: rst_n low, then high, with MODE=0, N_STATES=4 -> state=0, led=0001, step=0.
- Clean up press held 40 cycles: state goes 0->1 exactly 18 edges after the first low sample, with a single step pulse. Four presses -> led sequence 0010, 0100, 1000, 0001 (wrap).
- Bounce: low pulses of 5 cycles separated by 3 high cycles, for 60 cycles, then release -> state unchanged, step never high.
- WRAP=0, N_STATES=5: 6 up presses -> state saturates at 4 and the sixth press gives no step. Then 1 down press -> state 3.
- Up and down pressed on the same cycle and held -> simultaneous events, state unchanged, no step. MODE=1 at state 2 -> led=0111; MODE=2, N_STATES=8 at state 5 -> led=0101.
- rst_n pulsed low at counter=10 during a press, button kept held -> after release of reset the press is accepted 2^DEB_W+2 edges later (the synchroniser restarts from 0); state 0->1.
